sha256_padder: RTL and testbench

Upstream feeder for the SHA-256 compression core. It accepts a message as a stream of 32-bit big-endian words and applies FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit bit length. It assembles 512-bit blocks and drives the core's init/next/block/ready handshake. It issues init for the first block of a message and next for every later block, then pulses msg_done when the core's digest for the final block is valid.

---
 rtl/sha256_pkg.sv | 28 ++
 rtl/sha256_pad_gen.sv | 37 +++
 rtl/sha256_padder.sv | 169 ++++++++++++++++
 tb/tb_sha256_padder.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared definitions for the SHA-256 message padder.
//   - SHA-256 initial hash words H0_0..H0_7
//   - padder state encoding (FILL, PAD, ISSUE, WAIT, LEN)
//   - block geometry and padding constants
package sha256_pkg;

    localparam logic [31:0] H0_0 = 32'h6a09e667;
    localparam logic [31:0] H0_1 = 32'hbb67ae85;
    localparam logic [31:0] H0_2 = 32'h3c6ef372;
    localparam logic [31:0] H0_3 = 32'ha54ff53a;
    localparam logic [31:0] H0_4 = 32'h510e527f;
    localparam logic [31:0] H0_5 = 32'h9b05688c;
    localparam logic [31:0] H0_6 = 32'h1f83d9ab;
    localparam logic [31:0] H0_7 = 32'h5be0cd19;

    localparam int          BLOCK_WORDS = 16;
    localparam logic [7:0]  PAD_BYTE    = 8'h80;
    localparam int          LEN_WORD_HI = 14;

    typedef enum logic [2:0] {
        FILL  = 3'd0,
        PAD   = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        LEN   = 3'd4
    } state_t;

endpackage

// File: rtl/sha256_pad_gen.sv
// sha256_pad_gen: combinational padded-block builder.
// Ports:
//   i_buf    [511:0] raw block buffer, byte 0 in [511:504]
//   i_pos    [6:0]   first byte position that is not message data (0..64)
//   i_pad_en         place PAD_BYTE at i_pos (if i_pos < 64)
//   i_bitlen [63:0]  message length in bits
//   o_block  [511:0] data bytes below i_pos, optional 0x80, zero fill, and
//                    the length in words 14/15 when it fits
//   o_fits           length fits in this block (i_pos <= 55)
import sha256_pkg::*;

module sha256_pad_gen (
    input  logic [511:0] i_buf,
    input  logic [6:0]   i_pos,
    input  logic         i_pad_en,
    input  logic [63:0]  i_bitlen,
    output logic [511:0] o_block,
    output logic         o_fits
);

    always_comb begin
        o_block = '0;
        o_fits  = (i_pos <= 7'd55);
        for (int b = 0; b < 64; b++) begin
            if (7'(b) < i_pos) begin
                o_block[511-8*b -: 8] = i_buf[511-8*b -: 8];
            end else if (i_pad_en && (7'(b) == i_pos)) begin
                o_block[511-8*b -: 8] = PAD_BYTE;
            end
        end
        // Bytes 56..63 are already zero whenever the length fits.
        if (o_fits) begin
            o_block[511-32*LEN_WORD_HI -: 64] = i_bitlen;
        end
    end

endmodule

// File: rtl/sha256_padder.sv
// sha256_padder: FIPS 180-4 message padder feeding a SHA-256 core.
// Accepts 32-bit big-endian words, builds 512-bit blocks and drives the
// core's init/next/ready handshake; pulses msg_done when the digest of the
// final block is valid.
// Input handshake: a word transfers on a rising clk edge where
// in_valid && in_ready; in_data/in_last/in_nbytes must be stable meanwhile.
// Ports:
//   clk, reset_n (synchronous, active-low)
//   in_valid/in_ready/in_data/in_last/in_nbytes  message word stream
//   core_ready, core_init, core_next, core_block  core handshake
//   msg_done   one-cycle pulse, digest valid
//   dbg_state  current FSM state
//   blk_cnt    init/next pulses since reset (only with SHA256_PADDER_STATS_EN)
import sha256_pkg::*;

module sha256_padder #(
    parameter int LEN_W = 61
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_nbytes,
    input  logic         core_ready,
    output logic         core_init,
    output logic         core_next,
    output logic [511:0] core_block,
    output logic         msg_done,
    output logic [2:0]   dbg_state
`ifdef SHA256_PADDER_STATS_EN
    ,
    output logic [31:0]  blk_cnt
`endif
);

    state_t             r_state;
    logic [3:0]         r_idx;
    logic [LEN_W-1:0]   r_byte_cnt;
    logic               r_first;
    logic               r_need_extra;
    logic               r_final;
    logic               r_defer;
    logic [2:0]         r_last_nb;
    logic [511:0]       r_buf;

    logic               w_accept;
    logic [2:0]         w_nb_eff;
    logic [2:0]         w_add;
    logic [6:0]         w_pos;
    logic               w_pad_en;
    logic [511:0]       w_gen_buf;
    logic [63:0]        w_bitlen;
    logic [511:0]       w_gen_block;
    logic               w_fits;

    assign in_ready   = reset_n && (r_state == FILL);
    assign w_accept   = in_valid && in_ready;
    assign w_nb_eff   = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
    assign w_add      = in_last ? w_nb_eff : 3'd4;
    assign w_bitlen   = 64'({r_byte_cnt, 3'b000});

    // LEN reuses the generator on an empty buffer: position 0, and the pad
    // byte only if it did not fit at the end of the previous block.
    assign w_pos      = (r_state == LEN) ? 7'd0
                                         : ({1'b0, r_idx, 2'b00} + {4'b0000, r_last_nb});
    assign w_pad_en   = (r_state == LEN) ? r_defer : 1'b1;
    assign w_gen_buf  = (r_state == LEN) ? '0 : r_buf;

    sha256_pad_gen u_pad_gen (
        .i_buf    (w_gen_buf),
        .i_pos    (w_pos),
        .i_pad_en (w_pad_en),
        .i_bitlen (w_bitlen),
        .o_block  (w_gen_block),
        .o_fits   (w_fits)
    );

    // Pulses are qualified by core_ready in the same cycle.
    assign core_init  = (r_state == ISSUE) && core_ready && r_first;
    assign core_next  = (r_state == ISSUE) && core_ready && !r_first;
    assign msg_done   = (r_state == WAIT)  && core_ready && r_final;
    assign core_block = r_buf;
    assign dbg_state  = r_state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= FILL;
            r_idx        <= '0;
            r_byte_cnt   <= '0;
            r_first      <= 1'b1;
            r_need_extra <= 1'b0;
            r_final      <= 1'b0;
            r_defer      <= 1'b0;
            r_last_nb    <= '0;
            r_buf        <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        r_buf[{~r_idx, 5'd0} +: 32] <= in_data;
                        r_byte_cnt <= r_byte_cnt + LEN_W'(w_add);
                        if (in_last) begin
                            r_last_nb <= w_nb_eff;
                            r_state   <= PAD;
                        end else if (r_idx == 4'(BLOCK_WORDS - 1)) begin
                            r_final <= 1'b0;
                            r_state <= ISSUE;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                PAD: begin
                    r_buf        <= w_gen_block;
                    r_final      <= w_fits;
                    r_need_extra <= !w_fits;
                    r_defer      <= (w_pos == 7'd64);
                    r_state      <= ISSUE;
                end
                ISSUE: begin
                    if (core_ready) begin
                        r_first <= 1'b0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (core_ready) begin
                        r_idx <= '0;
                        if (r_final) begin
                            r_first    <= 1'b1;
                            r_byte_cnt <= '0;
                            r_final    <= 1'b0;
                            r_state    <= FILL;
                        end else if (r_need_extra) begin
                            r_state <= LEN;
                        end else begin
                            r_state <= FILL;
                        end
                    end
                end
                LEN: begin
                    r_buf        <= w_gen_block;
                    r_need_extra <= 1'b0;
                    r_final      <= 1'b1;
                    r_defer      <= 1'b0;
                    r_state      <= ISSUE;
                end
                default: r_state <= FILL;
            endcase
        end
    end

`ifdef SHA256_PADDER_STATS_EN
    logic [31:0] r_blk_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_blk_cnt <= '0;
        end else if (core_init || core_next) begin
            r_blk_cnt <= r_blk_cnt + 32'd1;
        end
    end

    assign blk_cnt = r_blk_cnt;
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: bench for sha256_padder with a behavioural SHA-256 core.
import sha256_pkg::*;

module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_nbytes;
    logic         core_ready;
    logic         core_init;
    logic         core_next;
    logic [511:0] core_block;
    logic         msg_done;
    logic [2:0]   dbg_state;
`ifdef SHA256_PADDER_STATS_EN
    logic [31:0]  blk_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int pulse_cnt    = 0;
    int pulse_base   = 0;
    int done_cnt     = 0;

    logic [511:0] exp_q[$];
    logic         exp_kind_q[$];
    logic [256:0] exp_dig_q[$];

    sha256_padder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_nbytes  (in_nbytes),
        .core_ready (core_ready),
        .core_init  (core_init),
        .core_next  (core_next),
        .core_block (core_block),
        .msg_done   (msg_done),
        .dbg_state  (dbg_state)
`ifdef SHA256_PADDER_STATS_EN
        ,
        .blk_cnt    (blk_cnt)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // behavioural SHA-256 core
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] H0_ALL = {H0_0, H0_1, H0_2, H0_3, H0_4, H0_5, H0_6, H0_7};

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
                e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   hh + hin[31:0]};
    endfunction

    logic         core_busy;
    logic         core_hold;
    int           core_lat;
    logic [255:0] m_h;

    assign core_ready = !core_busy && !core_hold;

    always @(posedge clk) begin
        if (!reset_n) begin
            core_busy <= 1'b0;
            core_lat  <= 0;
        end else if (core_init || core_next) begin
            m_h       <= compress(core_init ? H0_ALL : m_h, core_block);
            core_busy <= 1'b1;
            core_lat  <= int'($urandom_range(2, 6));
        end else if (core_busy) begin
            if (core_lat == 0) core_busy <= 1'b0;
            else core_lat <= core_lat - 1;
        end
    end

    // scoreboard
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (core_init === 1'b1 || core_next === 1'b1) begin
                pulse_cnt++;
                tests_run++;
                if (core_init === 1'b1 && core_next === 1'b1) begin
                    tests_failed++;
                    $display("FAIL init_next_excl: got init=%b next=%b, expected one of them", core_init, core_next);
                end
                tests_run++;
                if (core_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL pulse_ready: got core_ready=%b, expected 1", core_ready);
                end
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_pulse: got block %h, expected no pulse", core_block);
                end else begin
                    logic [511:0] eb;
                    logic         ek;
                    eb = exp_q.pop_front();
                    ek = exp_kind_q.pop_front();
                    tests_run++;
                    if (core_block !== eb) begin
                        tests_failed++;
                        $display("FAIL block: got %h, expected %h", core_block, eb);
                    end
                    tests_run++;
                    if (core_init !== ek) begin
                        tests_failed++;
                        $display("FAIL pulse_kind: got init=%b, expected init=%b", core_init, ek);
                    end
                end
            end
            if (msg_done === 1'b1) begin
                done_cnt++;
                if (exp_dig_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_done: got msg_done=1, expected 0");
                end else begin
                    logic [256:0] ed;
                    ed = exp_dig_q.pop_front();
                    if (ed[256]) begin
                        tests_run++;
                        if (m_h !== ed[255:0]) begin
                            tests_failed++;
                            $display("FAIL digest: got %h, expected %h", m_h, ed[255:0]);
                        end
                    end
                end
            end
        end
    end

    // drivers
    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int cnt;
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        in_nbytes = nb;
        cnt = 0;
        while (in_ready !== 1'b1 && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        if (in_ready !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL in_ready_timeout: got in_ready=%b, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int cnt;
        cnt = 0;
        while (done_cnt < target && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        tests_run++;
        if (done_cnt < target) begin
            tests_failed++;
            $display("FAIL done_timeout: got %0d msg_done, expected %0d", done_cnt, target);
        end
    endtask

    task automatic push_blk(input logic [511:0] b, input logic is_init);
        exp_q.push_back(b);
        exp_kind_q.push_back(is_init);
    endtask

    // tests
    task automatic test_reset();
        reset_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_nbytes = '0;
        core_hold = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_ready_low: got %b, expected 0", in_ready);
        end
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
        tests_run++;
        if ({core_init, core_next, msg_done} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_pulses: got %b, expected 000", {core_init, core_next, msg_done});
        end
        tests_run++;
        if (core_block !== 512'd0) begin
            tests_failed++;
            $display("FAIL reset_block: got %h, expected 0", core_block);
        end
    endtask

    task automatic test_abc();
        logic [511:0] e;
        int target;
        e = '0;
        e[511:480] = 32'h61626380;
        e[31:0]    = 32'h00000018;
        push_blk(e, 1'b1);
        exp_dig_q.push_back({1'b1, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad});
        target = done_cnt + 1;
        send_word(32'h61626300, 1'b1, 3'd3);
        @(negedge clk);
        tests_run++;
        if (core_init !== 1'b0) begin
            tests_failed++;
            $display("FAIL abc_latency_pad: got init=%b, expected 0", core_init);
        end
        @(negedge clk);
        tests_run++;
        if (core_init !== 1'b1) begin
            tests_failed++;
            $display("FAIL abc_latency_issue: got init=%b, expected 1", core_init);
        end
        wait_done(target);
    endtask

    task automatic test_empty();
        logic [511:0] e;
        int target;
        e = '0;
        e[511:480] = 32'h80000000;
        push_blk(e, 1'b1);
        exp_dig_q.push_back({1'b1, 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855});
        target = done_cnt + 1;
        send_word(32'hdeadbeef, 1'b1, 3'd0);
        wait_done(target);
    endtask

    task automatic test_partial();
        logic [511:0] e;
        logic [31:0]  d0, d1;
        int target;
        // one byte, trailing bytes masked
        e = '0;
        e[511:480] = 32'hAA800000;
        e[31:0]    = 32'h00000008;
        push_blk(e, 1'b1);
        exp_dig_q.push_back({1'b0, 256'd0});
        target = done_cnt + 1;
        send_word(32'hAABBCCDD, 1'b1, 3'd1);
        wait_done(target);
        // in_nbytes > 4 behaves as 4
        d0 = $urandom; d1 = $urandom;
        e = '0;
        e[511:480] = d0;
        e[479:448] = d1;
        e[447:416] = 32'h80000000;
        e[31:0]    = 32'h00000040;
        push_blk(e, 1'b1);
        exp_dig_q.push_back({1'b0, 256'd0});
        target = done_cnt + 1;
        send_word(d0, 1'b0, 3'd2);
        send_word(d1, 1'b1, 3'd7);
        wait_done(target);
    endtask

    task automatic test_55_bytes();
        logic [511:0] e;
        logic [31:0]  d;
        int target;
        e = '0;
        for (int i = 0; i < 14; i++) begin
            d = $urandom;
            e[511-32*i -: 32] = (i == 13) ? {d[31:8], 8'h80} : d;
            send_word(d, (i == 13), 3'd3);
            if (i == 0) begin
                push_blk(e, 1'b1);
            end
        end
        e[31:0] = 32'h000001B8;
        exp_q[exp_q.size()-1] = e;
        exp_dig_q.push_back({1'b0, 256'd0});
        target = done_cnt + 1;
        wait_done(target);
    endtask

    task automatic test_56_bytes();
        logic [511:0] e1, e2;
        logic [31:0]  w [14];
        int target;
        e1 = '0;
        for (int i = 0; i < 14; i++) begin
            w[i] = {8'(97 + i), 8'(98 + i), 8'(99 + i), 8'(100 + i)};
            e1[511-32*i -: 32] = w[i];
        end
        e1[63:32] = 32'h80000000;
        e2 = '0;
        e2[31:0] = 32'h000001C0;
        push_blk(e1, 1'b1);
        push_blk(e2, 1'b0);
        exp_dig_q.push_back({1'b1, 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1});
        target = done_cnt + 1;
        for (int i = 0; i < 14; i++) send_word(w[i], (i == 13), 3'd4);
        wait_done(target);
    endtask

    task automatic send_64(input logic hold);
        logic [511:0] e1, e2;
        logic [31:0]  w [16];
        int p0, target, bad_rdy, bad_pulse, bad_blk;
        e1 = '0;
        for (int i = 0; i < 16; i++) begin
            w[i] = $urandom;
            e1[511-32*i -: 32] = w[i];
        end
        e2 = '0;
        e2[511:480] = 32'h80000000;
        e2[31:0]    = 32'h00000200;
        push_blk(e1, 1'b1);
        push_blk(e2, 1'b0);
        exp_dig_q.push_back({1'b0, 256'd0});
        target = done_cnt + 1;
        core_hold = hold;
        for (int i = 0; i < 16; i++) send_word(w[i], (i == 15), 3'd4);
        if (hold) begin
            p0 = pulse_cnt;
            bad_rdy = 0; bad_pulse = 0; bad_blk = 0;
            @(negedge clk);
            for (int c = 0; c < 70; c++) begin
                @(negedge clk);
                if (in_ready !== 1'b0) bad_rdy++;
                if (core_init !== 1'b0 || core_next !== 1'b0) bad_pulse++;
                if (core_block !== e1) bad_blk++;
            end
            tests_run++;
            if (bad_rdy != 0) begin
                tests_failed++;
                $display("FAIL bp_in_ready: got %0d cycles with in_ready!=0, expected 0", bad_rdy);
            end
            tests_run++;
            if (bad_pulse != 0) begin
                tests_failed++;
                $display("FAIL bp_pulse: got %0d cycles with a pulse, expected 0", bad_pulse);
            end
            tests_run++;
            if (bad_blk != 0) begin
                tests_failed++;
                $display("FAIL bp_block_stable: got %0d cycles with changed block, expected 0", bad_blk);
            end
            core_hold = 1'b0;
            @(negedge clk);
            @(negedge clk);
            tests_run++;
            if (pulse_cnt != p0 + 1) begin
                tests_failed++;
                $display("FAIL bp_single_pulse: got %0d pulses, expected 1", pulse_cnt - p0);
            end
        end
        wait_done(target);
        repeat (20) @(negedge clk);
        tests_run++;
        if (done_cnt != target) begin
            tests_failed++;
            $display("FAIL done_once: got %0d msg_done, expected %0d", done_cnt, target);
        end
    endtask

    task automatic test_64_bytes();
        send_64(1'b0);
    endtask

    task automatic test_back_pressure();
        send_64(1'b1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) send_word($urandom, 1'b0, 3'd4);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        pulse_base = pulse_cnt;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset_in_ready: got %b, expected 1", in_ready);
        end
        test_abc();
    endtask

    // final report
    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_partial();
        test_55_bytes();
        test_56_bytes();
        test_64_bytes();
        test_back_pressure();
        test_reset_mid();
        repeat (10) @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0 || exp_dig_q.size() != 0) begin
            tests_failed++;
            $display("FAIL leftover: got %0d blocks %0d digests pending, expected 0 0", exp_q.size(), exp_dig_q.size());
        end
`ifdef SHA256_PADDER_STATS_EN
        tests_run++;
        if (blk_cnt !== 32'(pulse_cnt - pulse_base)) begin
            tests_failed++;
            $display("FAIL blk_cnt: got %0d, expected %0d", blk_cnt, pulse_cnt - pulse_base);
        end
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
